// File: rtl/fc_bias_act_pipe.sv
// rtl/fc_bias_act_pipe.sv - FC output stage: per-channel bias add, rounding shift, ReLU, saturation.
// Two-stage valid/ready pipeline with runtime bias registers and a clip-event counter.
module fc_bias_act_pipe #(
    parameter int CO      = 3,
    parameter int ACC_BW  = 20,
    parameter int BIAS_BW = 8,
    parameter int OUT_BW  = 8,
    parameter int SH_BW   = 4,
    parameter int CNT_BW  = 16,
    localparam int AW     = (CO > 1) ? $clog2(CO) : 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [CO*ACC_BW-1:0]   i_acc,
    input  logic [SH_BW-1:0]       i_shift,
    input  logic                   i_relu_en,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [CO*OUT_BW-1:0]   o_data,
    input  logic                   i_bias_we,
    input  logic [AW-1:0]          i_bias_addr,
    input  logic [BIAS_BW-1:0]     i_bias_data,
    input  logic                   i_sat_clr,
    output logic [CNT_BW-1:0]      o_sat_cnt
);

    localparam int SW = ACC_BW + 1;
    // One extra bit so the rounding increment can never overflow the sum.
    localparam int RW = ACC_BW + 2;
    localparam logic signed [RW-1:0] OMAX = {{(RW-OUT_BW+1){1'b0}}, {(OUT_BW-1){1'b1}}};
    localparam logic signed [RW-1:0] OMIN = {{(RW-OUT_BW+1){1'b1}}, {(OUT_BW-1){1'b0}}};

    logic signed [BIAS_BW-1:0] bias [CO];

    logic                  s1_valid;
    logic signed [SW-1:0]  s1_sum [CO];
    logic [SH_BW-1:0]      s1_shift;
    logic                  s1_relu;

    logic                  s2_valid;
    logic                  s2_sat;
    logic [CO*OUT_BW-1:0]  s2_data;

    logic                  adv1;
    logic                  adv2;
    logic [CO*OUT_BW-1:0]  s2_next;
    logic                  sat_next;
    logic signed [RW-1:0]  ext;
    logic signed [RW-1:0]  rnd;
    logic signed [RW-1:0]  res;

    always_comb begin
        adv2 = !s2_valid || i_ready;
        adv1 = !s1_valid || adv2;
    end

    assign o_ready = adv1;
    assign o_valid = s2_valid;
    assign o_data  = s2_data;

    // Out-of-range addresses match no channel and are dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < CO; c++) bias[c] <= '0;
        end else if (i_bias_we) begin
            for (int c = 0; c < CO; c++)
                if (i_bias_addr == AW'(c)) bias[c] <= i_bias_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_shift <= '0;
            s1_relu  <= 1'b0;
            for (int c = 0; c < CO; c++) s1_sum[c] <= '0;
        end else if (adv1) begin
            s1_valid <= i_valid;
            if (i_valid) begin
                s1_shift <= i_shift;
                s1_relu  <= i_relu_en;
                for (int c = 0; c < CO; c++)
                    s1_sum[c] <= $signed({i_acc[c*ACC_BW+ACC_BW-1], i_acc[c*ACC_BW +: ACC_BW]})
                               + $signed({{(SW-BIAS_BW){bias[c][BIAS_BW-1]}}, bias[c]});
            end
        end
    end

    always_comb begin
        s2_next  = '0;
        sat_next = 1'b0;
        ext      = '0;
        rnd      = '0;
        res      = '0;
        for (int c = 0; c < CO; c++) begin
            ext = {s1_sum[c][SW-1], s1_sum[c]};
            rnd = '0;
            if (s1_shift != '0) rnd = RW'(1) << (s1_shift - 1'b1);
            res = (ext + rnd) >>> s1_shift;
            if (s1_relu && res[RW-1]) res = '0;
            if (res > OMAX) begin
                res      = OMAX;
                sat_next = 1'b1;
            end else if (res < OMIN) begin
                res      = OMIN;
                sat_next = 1'b1;
            end
            s2_next[c*OUT_BW +: OUT_BW] = res[OUT_BW-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid <= 1'b0;
            s2_sat   <= 1'b0;
            s2_data  <= '0;
        end else if (adv2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data <= s2_next;
                s2_sat  <= sat_next;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_sat_cnt <= '0;
        end else if (i_sat_clr) begin
            o_sat_cnt <= '0;
        end else if (s2_valid && i_ready && s2_sat && (o_sat_cnt != '1)) begin
            o_sat_cnt <= o_sat_cnt + 1'b1;
        end
    end

endmodule
